const_fold_accum: RTL and testbench

Parametrised constant-stepping accumulator used as a folding and elaboration target for the transformation passes. A compile-time step value, derived entirely from parameter arithmetic, is added to a WIDTH-bit register for a fixed number of cycles. A tapped bit of the register conditionally captures a zero-extended copy into a wider register, and a constant mask output is driven.

---
 rtl/const_fold_pkg.sv | 39 +++
 rtl/const_fold_step_add.sv | 45 ++++
 rtl/const_fold_accum.sv | 141 ++++++++++++++
 tb/tb_const_fold_accum.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/const_fold_pkg.sv
// Shared types and elaboration-time constants for const_fold_accum.
package const_fold_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH     = 2**2 * 2**3;
  localparam int DEF_EXT       = 2;
  localparam int DEF_STEP      = 1 + 2*12 - 3**5 + -1 + 1;
  localparam int DEF_TAP       = 32 - 31;
  localparam int DEF_RUN_LEN   = 2**4;
  localparam int DEF_MASK_W    = 48;
  localparam int DEF_MASK_ONES = 8;

  // Smallest two's-complement width that holds v without loss.
  function automatic int signed_bits(input int v);
    int mag;
    int n;
    mag = (v < 0) ? (-v - 1) : v;
    n   = 1;
    for (int i = 0; i < 31; i++) begin
      if ((mag >> i) != 0) begin
        n = i + 2;
      end
    end
    return n;
  endfunction

  // Counter width able to index 0 .. n-1 (never narrower than one bit).
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int STEP_W = signed_bits(DEF_STEP);

endpackage

// File: rtl/const_fold_step_add.sv
// Constant-step WIDTH-bit adder; saturating when CONST_FOLD_ACCUM_SATURATE_EN is defined.
module const_fold_step_add
  import const_fold_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);

  localparam int                     SW     = signed_bits(STEP);
  localparam logic signed [SW-1:0]   STEP_N = SW'(STEP);
  // Signed source, so this sign-extends or truncates to WIDTH.
  localparam logic [WIDTH-1:0]       STEP_V = WIDTH'(STEP_N);

  logic [WIDTH-1:0] raw_s;

  assign raw_s = a + STEP_V;

`ifdef CONST_FOLD_ACCUM_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic ovf_s;

  // Overflow only when both operands share a sign the result lacks.
  always_comb begin
    ovf_s = (a[WIDTH-1] == STEP_V[WIDTH-1]) && (raw_s[WIDTH-1] != a[WIDTH-1]);
    sat   = ovf_s;
    if (!ovf_s) begin
      sum = raw_s;
    end else if (a[WIDTH-1]) begin
      sum = MIN_NEG;
    end else begin
      sum = MAX_POS;
    end
  end
`else
  assign sum = raw_s;
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/const_fold_accum.sv
// Constant-stepping accumulator with tap-triggered capture and constant mask output.
// Optional build macro: CONST_FOLD_ACCUM_SATURATE_EN (signed-saturating add).
module const_fold_accum
  import const_fold_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXT       = DEF_EXT,
  parameter int STEP      = DEF_STEP,
  parameter int TAP       = DEF_TAP,
  parameter int RUN_LEN   = DEF_RUN_LEN,
  parameter int MASK_W    = DEF_MASK_W,
  parameter int MASK_ONES = DEF_MASK_ONES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 load_en,
  input  logic [WIDTH-1:0]     load_val,
  output logic [WIDTH-1:0]     out1,
  output logic [EXT*WIDTH-1:0] out2,
  output logic [MASK_W-1:0]    out3,
  output logic                 capture_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 sat
);

  localparam int                CNT_W    = cnt_bits(RUN_LEN);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RUN_LEN - 1);
  localparam logic [MASK_W-1:0] ALL_ONES = '1;
  localparam logic [MASK_W-1:0] MASK_V   = ALL_ONES << (MASK_W - MASK_ONES);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     out1_q, out1_d;
  logic [EXT*WIDTH-1:0] out2_q, out2_d;
  logic                 capture_valid_q, capture_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sat_q, sat_d;
  logic [WIDTH-1:0]     sum_s;
  logic                 sat_s;

  const_fold_step_add #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step_add (
    .a   (out1_q),
    .sum (sum_s),
    .sat (sat_s)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    out1_d          = out1_q;
    out2_d          = out2_q;
    capture_valid_d = 1'b0;
    busy_d          = busy_q;
    done_d          = 1'b0;
    sat_d           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          out1_d = load_val;
        end else begin
          out1_d = out1_q;
        end
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        out1_d = sum_s;
        sat_d  = sat_s;
        cnt_d  = cnt_q + CNT_W'(1);
        // Capture uses the pre-add value of the accumulator.
        if (out1_q[TAP]) begin
          out2_d          = (EXT*WIDTH)'(out1_q);
          capture_valid_d = 1'b1;
        end else begin
          out2_d = out2_q;
        end
        if (stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      out1_q          <= '0;
      out2_q          <= '0;
      capture_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      sat_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      out1_q          <= out1_d;
      out2_q          <= out2_d;
      capture_valid_q <= capture_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      sat_q           <= sat_d;
    end
  end

  assign out1          = out1_q;
  assign out2          = out2_q;
  assign out3          = MASK_V;
  assign capture_valid = capture_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sat           = sat_q;

endmodule

// File: tb/tb_const_fold_accum.sv
// Scoreboard bench for const_fold_accum at default parameters.
module tb_const_fold_accum;

  localparam int STEP = -218;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        load_en;
  logic [31:0] load_val;
  logic [31:0] out1;
  logic [63:0] out2;
  logic [47:0] out3;
  logic        capture_valid;
  logic        busy;
  logic        done;
  logic        sat;

  int          n_cmp;
  int          n_err;
  logic [63:0] exp_q[$];

  const_fold_accum dut (
    .clock         (clk),
    .reset         (rst),
    .start         (start),
    .stop          (stop),
    .load_en       (load_en),
    .load_val      (load_val),
    .out1          (out1),
    .out2          (out2),
    .out3          (out3),
    .capture_valid (capture_valid),
    .busy          (busy),
    .done          (done),
    .sat           (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the captures a run of n adds starting from v0 must produce.
  task automatic push_run(input logic [31:0] v0, input int n);
    logic [31:0] pre;
    for (int k = 0; k < n; k++) begin
      pre = v0 + k * STEP;
      if (pre[1]) exp_q.push_back({32'h0, pre});
    end
  endtask

  // Capture monitor: every capture_valid pulse pops one expected out2.
  always @(posedge clk) begin
    #1;
    if (capture_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("cap_unexpected", {32'h0, out2[31:0]}, 64'h0);
      end else begin
        chk("cap_out2", out2, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] exp1;
    int busy_cnt;
    int done_cnt;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; load_en = 1'b0; load_val = 32'h0;

    // Reset held
    step(); step();
    chk("rst_out1", out1, 64'h0);
    chk("rst_out2", out2, 64'h0);
    chk("rst_cv", capture_valid, 64'h0);
    chk("rst_busy", busy, 64'h0);
    chk("rst_done", done, 64'h0);
    chk("rst_sat", sat, 64'h0);
    chk("rst_out3", out3, 64'h0000_FF00_0000_0000);
    rst = 1'b0;
    step();
    chk("idle_out1", out1, 64'h0);

    // Full run from zero, with start and load_en poked mid-run
    push_run(32'h0, 16);
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = busy; done_cnt = done;
    chk("run_out1_0", out1, 64'h0);
    for (int i = 1; i <= 17; i++) begin
      if (i == 3) begin
        start = 1'b1; load_en = 1'b1; load_val = 32'h1234_5678;
      end
      step();
      start = 1'b0; load_en = 1'b0;
      busy_cnt += busy; done_cnt += done;
      exp1 = i * STEP;
      if (i <= 16) chk("run_out1", out1, {32'h0, exp1});
      if (i == 1) chk("first_add", out1, 64'hFFFF_FF26);
      if (i == 2) begin
        chk("cap2_cv", capture_valid, 64'h1);
        chk("cap2_out2", out2, 64'h0000_0000_FFFF_FF26);
      end
      if (i == 4) chk("cap4_out2", out2, 64'h0000_0000_FFFF_FD72);
      if (i == 16) begin
        chk("done_pulse", done, 64'h1);
        chk("done_busy", busy, 64'h0);
      end
      if (i == 17) chk("done_clear", done, 64'h0);
    end
    chk("busy_cycles", busy_cnt, 64'd16);
    chk("done_count", done_cnt, 64'd1);

    // Stop on the 5th RUN cycle
    load_en = 1'b1; load_val = 32'h0;
    step();
    load_en = 1'b0;
    chk("load_zero", out1, 64'h0);
    push_run(32'h0, 5);
    start = 1'b1;
    step();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) stop = 1'b1;
      step();
      stop = 1'b0;
      done_cnt += done;
    end
    chk("stop_out1", out1, 64'hFFFF_FBBE);
    chk("stop_busy", busy, 64'h0);
    step(); step();
    done_cnt += done;
    chk("stop_hold", out1, 64'hFFFF_FBBE);
    chk("stop_nodone", done_cnt, 64'd0);

    // Load + start together, then one add crossing the negative limit
    load_en = 1'b1; start = 1'b1; load_val = 32'h8000_0010;
    push_run(32'h8000_0010, 1);
    step();
    load_en = 1'b0; start = 1'b0;
    chk("ls_out1", out1, 64'h8000_0010);
    chk("ls_busy", busy, 64'h1);
    stop = 1'b1;
    step();
    stop = 1'b0;
`ifdef CONST_FOLD_ACCUM_SATURATE_EN
    chk("ovf_out1", out1, 64'h8000_0000);
    chk("ovf_sat", sat, 64'h1);
`else
    chk("ovf_out1", out1, 64'h7FFF_FF36);
    chk("ovf_sat", sat, 64'h0);
`endif
    step();
    chk("sat_clear", sat, 64'h0);

    // Asynchronous reset during the 7th RUN cycle
    load_en = 1'b1; load_val = 32'h0;
    step();
    load_en = 1'b0;
    push_run(32'h0, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) step();
    exp1 = 6 * STEP;
    chk("pre_rst_out1", out1, {32'h0, exp1});
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out1", out1, 64'h0);
    chk("arst_out2", out2, 64'h0);
    chk("arst_cv", capture_valid, 64'h0);
    chk("arst_busy", busy, 64'h0);
    chk("arst_done", done, 64'h0);
    chk("arst_out3", out3, 64'h0000_FF00_0000_0000);
    step();
    rst = 1'b0;
    step(); step();
    chk("post_rst_busy", busy, 64'h0);
    chk("post_rst_out1", out1, 64'h0);

    chk("sb_empty", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
